// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : btn_conditioner
// Purpose  : Front end for the four board push-buttons. Each raw pin is
//            synchronised into the clk domain by a 2-FF chain, debounced by a
//            per-channel stability counter, and registered onto the outputs.
//            Opposing directions (left + right) cancel each other. A one-cycle
//            pulse marks the debounced jump rising edge.
// Ports    : clk         - pixel clock
//            rst         - synchronous, active-high reset
//            btn_left    - raw asynchronous left button
//            btn_right   - raw asynchronous right button
//            btn_jump    - raw asynchronous jump button
//            btn_down    - raw asynchronous down button
//            stepleft    - debounced left, suppressed while right is held
//            stepright   - debounced right, suppressed while left is held
//            stepjump    - debounced jump level
//            buttondown  - debounced down level
//            jump_pulse  - single-cycle pulse on debounced jump rising edge
// Revision : 1.0 - initial release
// ============================================================================
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 650000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_jump,
  input  logic btn_down,
  output logic stepleft,
  output logic stepright,
  output logic stepjump,
  output logic buttondown,
  output logic jump_pulse
);

  localparam int            C_NUM_CH  = 4;
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Channel order: 0 = left, 1 = right, 2 = jump, 3 = down
  logic [C_NUM_CH-1:0] w_raw;
  logic [C_NUM_CH-1:0] w_stable;

  assign w_raw = {btn_down, btn_jump, btn_right, btn_left};

  generate
    for (genvar g = 0; g < C_NUM_CH; g++) begin : g_chan
      logic             sync1_q;
      logic             sync2_q;
      logic             stable_q;
      logic             stable_d;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      // A disagreeing sample extends the run; any agreeing sample clears it.
      // The level only moves once the run reaches DEBOUNCE_CYCLES samples.
      always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
          if (cnt_q == C_CNT_MAX) begin
            stable_d = sync2_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_q  <= 1'b0;
          sync2_q  <= 1'b0;
          stable_q <= 1'b0;
          cnt_q    <= '0;
        end else begin
          sync1_q  <= w_raw[g];
          sync2_q  <= sync1_q;
          stable_q <= stable_d;
          cnt_q    <= cnt_d;
        end
      end

      assign w_stable[g] = stable_q;
    end
  endgenerate

  logic stable_j_d_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stepleft     <= 1'b0;
      stepright    <= 1'b0;
      stepjump     <= 1'b0;
      buttondown   <= 1'b0;
      jump_pulse   <= 1'b0;
      stable_j_d_q <= 1'b0;
    end else begin
      stepleft     <= w_stable[0] & ~w_stable[1];
      stepright    <= w_stable[1] & ~w_stable[0];
      stepjump     <= w_stable[2];
      buttondown   <= w_stable[3];
      // stable_j_d_q trails w_stable[2] by one cycle, so the pulse lines up
      // with the registered stepjump rising edge.
      jump_pulse   <= w_stable[2] & ~stable_j_d_q;
      stable_j_d_q <= w_stable[2];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_conditioner
// Purpose  : Self-checking bench for btn_conditioner. A behavioural model
//            predicts every output per clock edge and queues it; a monitor
//            pops the queue on the falling edge and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_conditioner;

  localparam int C_DEB = 4;

  logic clk;
  logic rst;
  logic btn_left, btn_right, btn_jump, btn_down;
  logic stepleft, stepright, stepjump, buttondown, jump_pulse;

  btn_conditioner #(.DEBOUNCE_CYCLES(C_DEB)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_jump   (btn_jump),
    .btn_down   (btn_down),
    .stepleft   (stepleft),
    .stepright  (stepright),
    .stepjump   (stepjump),
    .buttondown (buttondown),
    .jump_pulse (jump_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    bit l;
    bit r;
    bit j;
    bit d;
    bit p;
  } exp_t;

  exp_t expq[$];
  int   errors    = 0;
  int   checks    = 0;
  int   pulse_cnt = 0;

  // ---------------- reference model state ----------------
  // effq   : effective pin values at recent edges (reset forces 0)
  // seenq  : samples reaching the debouncer since the last reset
  // lvl    : debounced level per channel
  bit effq  [4][$];
  bit seenq [4][$];
  bit lvl   [4];
  bit lvl_j_prev;

  task automatic check(input string name, input bit act, input bit expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (jump_pulse === 1'b1) pulse_cnt++;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      check("stepleft",   stepleft,   e.l);
      check("stepright",  stepright,  e.r);
      check("stepjump",   stepjump,   e.j);
      check("buttondown", buttondown, e.d);
      check("jump_pulse", jump_pulse, e.p);
    end
  end

  // Apply one clock of stimulus. b = {down, jump, right, left}.
  task automatic step(input bit r, input bit [3:0] b);
    exp_t e;
    bit   seen;
    bit   all_diff;
    rst       = r;
    btn_left  = b[0];
    btn_right = b[1];
    btn_jump  = b[2];
    btn_down  = b[3];
    @(posedge clk);
    // Outputs at this edge reflect the debounced levels held before it.
    if (r) begin
      e = '0;
    end else begin
      e.l = lvl[0] & ~lvl[1];
      e.r = lvl[1] & ~lvl[0];
      e.j = lvl[2];
      e.d = lvl[3];
      e.p = lvl[2] & ~lvl_j_prev;
    end
    expq.push_back(e);
    lvl_j_prev = r ? 1'b0 : lvl[2];
    for (int ch = 0; ch < 4; ch++) begin
      if (r) begin
        effq[ch]  = '{1'b0, 1'b0};
        seenq[ch] = {};
        lvl[ch]   = 1'b0;
      end else begin
        // Pin value from two edges ago reaches the debouncer now.
        seen = effq[ch][effq[ch].size() - 2];
        effq[ch].push_back(b[ch]);
        while (effq[ch].size() > 2) void'(effq[ch].pop_front());
        seenq[ch].push_back(seen);
        while (seenq[ch].size() > C_DEB) void'(seenq[ch].pop_front());
        // Level flips once the latest C_DEB samples all disagree with it.
        if (seenq[ch].size() == C_DEB) begin
          all_diff = 1'b1;
          foreach (seenq[ch][k]) if (seenq[ch][k] == lvl[ch]) all_diff = 1'b0;
          if (all_diff) lvl[ch] = seen;
        end
      end
    end
    #1;
  endtask

  task automatic hold(input int n, input bit [3:0] b);
    for (int i = 0; i < n; i++) step(1'b0, b);
  endtask

  initial begin
    bit [3:0] rb;
    int       p0;
    int       guard;
    for (int ch = 0; ch < 4; ch++) begin
      effq[ch] = '{1'b0, 1'b0};
      lvl[ch]  = 1'b0;
    end
    lvl_j_prev = 1'b0;

    // Reset, then jump pressed and released
    repeat (3) step(1'b1, 4'b0000);
    hold(12, 4'b0100);
    hold(12, 4'b0000);

    // Left glitch train never settles, then a solid hold
    for (int i = 0; i < 4; i++) begin
      hold(3, 4'b0001);
      hold(1, 4'b0000);
    end
    hold(12, 4'b0001);

    // Left held, right added, then left released, then right released
    hold(12, 4'b0011);
    hold(12, 4'b0010);
    hold(12, 4'b0000);

    // Jump held, released, re-pressed: exactly two pulses
    @(negedge clk); #1;
    p0 = pulse_cnt;
    hold(20, 4'b0100);
    hold(10, 4'b0000);
    hold(12, 4'b0100);
    hold(10, 4'b0000);
    @(negedge clk); #1;
    checks++;
    if (pulse_cnt - p0 != 2) begin
      errors++;
      $display("FAIL jump_pulse_count: got %0d expected 2", pulse_cnt - p0);
    end

    // Down counter interrupted by reset, then completes after release
    hold(4, 4'b1000);
    step(1'b1, 4'b1000);
    hold(12, 4'b1000);
    hold(12, 4'b0000);

    // All four together
    hold(12, 4'b1111);
    hold(12, 4'b0000);

    // Randomised traffic with occasional reset
    rb = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      for (int ch = 0; ch < 4; ch++)
        if ($urandom_range(5) == 0) rb[ch] = ~rb[ch];
      step($urandom_range(199) == 0, rb);
    end

    guard = 0;
    while (expq.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    #1;
    if (expq.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left, expected 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
